// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the divider monitor family.
//   state_t          measurement FSM states
//   SAT              all-ones value of a default-width counter
//   DEF_*            default parameter values for div_monitor / sync_edge
package div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_TIMEOUT     = 1024;

  localparam logic [DEF_CNT_W-1:0] SAT = {DEF_CNT_W{1'b1}};

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser for an asynchronous / glitchy level,
// followed by a one-cycle-delayed copy used for edge detection.
//   clk    system clock (posedge)
//   reset  synchronous, active-high
//   level  raw input level (e.g. a divider tap)
//   s      synchronised level (last synchroniser flop)
//   rise   s & ~prev, combinational
//   fall   ~s & prev, combinational
module sync_edge
  import div_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], level};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

endmodule

// File: rtl/div_monitor.sv
// div_monitor: watches the divided clock from the upstream divider.
// Emits a tick per rising edge, measures period and high width in clk
// cycles, counts ticks and flags a stalled divider via a watchdog.
//   clk           system clock (posedge)
//   reset         synchronous, active-high
//   div_in        divided-clock level (may glitch, changes on both edges)
//   clear         zeroes tick_count, period, high_width (FSM untouched)
//   tick          one-cycle strobe per rising edge of div_in
//   period        last rising-to-rising interval, clk cycles (saturating)
//   high_width    last rising-to-falling interval, clk cycles (saturating)
//   period_valid  one-cycle strobe when period is updated
//   tick_count    ticks since reset/clear, wraps
//   stalled       high while no rising edge for TIMEOUT cycles
// CNT_W is limited to at most 32 bits (width of div_pkg::SAT).
module div_monitor
  import div_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_in,
  input  logic             clear,
  output logic             tick,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_width,
  output logic             period_valid,
  output logic [CNT_W-1:0] tick_count,
  output logic             stalled
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SAT);

  // Compare at >= 32 bits so a TIMEOUT beyond the counter range simply
  // never fires instead of aliasing onto a truncated value.
  localparam int            TW      = (CNT_W > 32) ? CNT_W : 32;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic             s;
  logic             rise;
  logic             fall;
  logic             timeout_hit;
  state_t           state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] hi_cnt;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .level (div_in),
    .s     (s),
    .rise  (rise),
    .fall  (fall)
  );

  assign timeout_hit = (TW'(cyc_cnt) == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cyc_cnt      <= '0;
      hi_cnt       <= '0;
      tick         <= 1'b0;
      period_valid <= 1'b0;
      stalled      <= 1'b0;
      period       <= '0;
      high_width   <= '0;
      tick_count   <= '0;
    end else begin
      tick         <= rise;
      period_valid <= 1'b0;
      cyc_cnt      <= rise ? '0 : sat_inc(cyc_cnt);

      if (rise)   hi_cnt <= '0;
      else if (s) hi_cnt <= sat_inc(hi_cnt);

      // A rise always beats the timeout condition in the same cycle.
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state <= ST_MEASURE;
          end else if (timeout_hit) begin
            state   <= ST_TIMEOUT;
            stalled <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (rise) begin
            if (!clear) begin
              period       <= sat_inc(cyc_cnt);
              period_valid <= 1'b1;
            end
          end else if (timeout_hit) begin
            state   <= ST_TIMEOUT;
            stalled <= 1'b1;
          end
          if (fall) high_width <= sat_inc(hi_cnt);
        end
        ST_TIMEOUT: begin
          // Interval since the last edge is unbounded: re-arm only.
          if (rise) begin
            state   <= ST_MEASURE;
            stalled <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          stalled <= 1'b0;
        end
      endcase

      // clear overrides any measurement loaded above; a coincident rise
      // still counts as the first tick after the clear.
      if (clear) begin
        period     <= '0;
        high_width <= '0;
        tick_count <= rise ? CNT_W'(1) : '0;
      end else if (rise) begin
        tick_count <= tick_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_div_monitor.sv
module tb_div_monitor;

  localparam int SS   = 2;
  localparam int HMAX = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, clr_a, din_a, tick_a, pv_a, st_a;
  logic [31:0] per_a, hw_a, tc_a;
  logic        rst_b, clr_b, din_b, tick_b, pv_b, st_b;
  logic [3:0]  per_b, hw_b, tc_b;

  div_monitor #(.SYNC_STAGES(SS), .CNT_W(32), .TIMEOUT(16)) dut_a (
    .clk(clk), .reset(rst_a), .div_in(din_a), .clear(clr_a), .tick(tick_a),
    .period(per_a), .high_width(hw_a), .period_valid(pv_a),
    .tick_count(tc_a), .stalled(st_a));

  div_monitor #(.SYNC_STAGES(SS), .CNT_W(4), .TIMEOUT(1024)) dut_b (
    .clk(clk), .reset(rst_b), .div_in(din_b), .clear(clr_b), .tick(tick_b),
    .period(per_b), .high_width(hw_b), .period_valid(pv_b),
    .tick_count(tc_b), .stalled(st_b));

  typedef struct {
    int     due;
    bit     pv;
    longint per;
    longint hw;
    longint tc;
  } rec_t;

  rec_t sb_a[$];
  rec_t sb_b[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model state, indexed 0 = dut_a, 1 = dut_b.
  bit     hist [2][HMAX];
  int     last_rst[2];
  int     last_ref[2];
  int     mst[2];        // 0 idle, 1 measuring, 2 timed out
  longint m_per[2], m_hw[2], m_tc[2];
  longint maxc[2];
  int     tmo[2];
  int     last_tick[2];
  int     stall_rise[2];
  bit     st_prev[2];
  int     k0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  // Driven level at cycle t, as the synchroniser would have captured it.
  function automatic bit hv(input int i, input int t);
    if (t < 0 || t <= last_rst[i]) return 1'b0;
    return hist[i][t];
  endfunction

  // Predict the effect of the upcoming posedge and queue a tick record.
  task automatic model_step(input int i, input bit r, input bit c);
    bit     rise, fall;
    longint d;
    rec_t   rc;
    if (r) begin
      mst[i] = 0; m_per[i] = 0; m_hw[i] = 0; m_tc[i] = 0;
      last_ref[i] = cyc; last_rst[i] = cyc;
      return;
    end
    rise = hv(i, cyc - SS) && !hv(i, cyc - SS - 1);
    fall = !hv(i, cyc - SS) && hv(i, cyc - SS - 1);
    d = cyc - last_ref[i];
    if (d > maxc[i]) d = maxc[i];
    if (rise) begin
      rc.pv = (mst[i] == 1) && !c;
      if (c) begin
        m_per[i] = 0; m_hw[i] = 0; m_tc[i] = 1;
      end else begin
        if (rc.pv) m_per[i] = d;
        m_tc[i] = (m_tc[i] + 1) & maxc[i];
      end
      mst[i] = 1;
      last_ref[i] = cyc;
      rc.due = cyc; rc.per = m_per[i]; rc.hw = m_hw[i]; rc.tc = m_tc[i];
      if (i == 0) sb_a.push_back(rc); else sb_b.push_back(rc);
    end else begin
      if (fall && mst[i] == 1) m_hw[i] = d;
      if (c) begin m_per[i] = 0; m_hw[i] = 0; m_tc[i] = 0; end
      if (mst[i] != 2 && (cyc - last_ref[i]) == tmo[i] && longint'(tmo[i] - 1) <= maxc[i])
        mst[i] = 2;
    end
  endtask

  task automatic monitor(input int i);
    logic        t, p, s;
    logic [63:0] per, hw, tc;
    bit          exp_tick;
    rec_t        rc;
    string       nm;
    if (i == 0) begin
      nm = "a"; t = tick_a; p = pv_a; s = st_a;
      per = 64'(per_a); hw = 64'(hw_a); tc = 64'(tc_a);
      exp_tick = (sb_a.size() > 0) && (sb_a[0].due == cyc);
      if (exp_tick) rc = sb_a.pop_front();
    end else begin
      nm = "b"; t = tick_b; p = pv_b; s = st_b;
      per = 64'(per_b); hw = 64'(hw_b); tc = 64'(tc_b);
      exp_tick = (sb_b.size() > 0) && (sb_b[0].due == cyc);
      if (exp_tick) rc = sb_b.pop_front();
    end
    chk($sformatf("%s.tick", nm), 64'(t), 64'(exp_tick));
    if (exp_tick) begin
      chk($sformatf("%s.period_valid", nm), 64'(p), 64'(rc.pv));
      chk($sformatf("%s.period", nm), per, rc.per);
      chk($sformatf("%s.high_width", nm), hw, rc.hw);
      chk($sformatf("%s.tick_count", nm), tc, rc.tc);
    end else begin
      chk($sformatf("%s.period_valid_idle", nm), 64'(p), 64'd0);
    end
    chk($sformatf("%s.stalled", nm), 64'(s), 64'(mst[i] == 2));
    if (t === 1'b1) last_tick[i] = cyc;
    if (s === 1'b1 && !st_prev[i]) stall_rise[i] = cyc;
    st_prev[i] = (s === 1'b1);
  endtask

  task automatic step();
    if (cyc >= HMAX) begin
      $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, HMAX);
      $fatal(1);
    end
    hist[0][cyc] = din_a;
    hist[1][cyc] = din_b;
    model_step(0, rst_a, clr_a);
    model_step(1, rst_b, clr_b);
    @(posedge clk);
    #1;
    monitor(0);
    monitor(1);
    cyc++;
  endtask

  task automatic drive(input int i, input bit v, input int n);
    repeat (n) begin
      if (i == 0) din_a = v; else din_b = v;
      step();
    end
  endtask

  task automatic run(input int i, input int hi, input int lo, input int reps);
    repeat (reps) begin
      drive(i, 1'b1, hi);
      drive(i, 1'b0, lo);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    maxc[0] = 64'hFFFF_FFFF; maxc[1] = 15;
    tmo[0]  = 16;            tmo[1]  = 1024;
    for (int i = 0; i < 2; i++) begin
      last_rst[i] = -1; last_ref[i] = 0; mst[i] = 0;
      m_per[i] = 0; m_hw[i] = 0; m_tc[i] = 0;
      last_tick[i] = -1; stall_rise[i] = -1; st_prev[i] = 1'b0;
    end
    rst_a = 1'b1; clr_a = 1'b0; din_a = 1'b0;
    rst_b = 1'b1; clr_b = 1'b0; din_b = 1'b0;
    repeat (3) step();
    rst_a = 1'b0; rst_b = 1'b0;

    // Reset state
    chk("a.rst.period", 64'(per_a), 0);
    chk("a.rst.high_width", 64'(hw_a), 0);
    chk("a.rst.tick_count", 64'(tc_a), 0);
    chk("b.rst.tick_count", 64'(tc_b), 0);

    // Divide-by-4, 2 high / 2 low; first tick SS cycles after first high sample
    k0 = cyc;
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 2);
    chk("a.first_tick_latency", 64'(last_tick[0] - k0), SS);
    run(0, 2, 2, 5);
    chk("a.div4.period", 64'(per_a), 4);
    chk("a.div4.high_width", 64'(hw_a), 2);
    chk("a.div4.tick_count", 64'(tc_a), 6);

    // Reset, then divide-by-5 with high width 3 for 10 periods
    rst_a = 1'b1; step(); rst_a = 1'b0;
    run(0, 3, 2, 10);
    drive(0, 1'b0, 3);
    chk("a.div5.period", 64'(per_a), 5);
    chk("a.div5.high_width", 64'(hw_a), 3);
    chk("a.div5.tick_count", 64'(tc_a), 10);

    // Stall: hold low, stalled rises TIMEOUT cycles after the last tick
    drive(0, 1'b0, 30);
    chk("a.stall.level", 64'(st_a), 1);
    chk("a.stall.latency", 64'(stall_rise[0] - last_tick[0]), 16);
    // Resume: first rise re-arms without updating period
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 1);
    chk("a.resume.stalled", 64'(st_a), 0);
    chk("a.resume.period_held", 64'(per_a), 5);
    drive(0, 1'b0, 1);
    run(0, 2, 2, 3);
    chk("a.resume.period", 64'(per_a), 4);

    // Clear during steady divide-by-4
    run(0, 2, 2, 2);
    clr_a = 1'b1; din_a = 1'b1; step(); clr_a = 1'b0;
    chk("a.clear.tick_count", 64'(tc_a), 0);
    chk("a.clear.period", 64'(per_a), 0);
    chk("a.clear.high_width", 64'(hw_a), 0);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 2);
    chk("a.after_clear.tick_count", 64'(tc_a), 1);
    chk("a.after_clear.period", 64'(per_a), 4);
    run(0, 2, 2, 2);
    chk("a.after_clear.tick_count2", 64'(tc_a), 3);
    chk("a.after_clear.high_width", 64'(hw_a), 2);

    // Reset mid-stream for one cycle
    run(0, 2, 2, 2);
    din_a = 1'b1; rst_a = 1'b1; step(); rst_a = 1'b0;
    chk("a.midrst.period", 64'(per_a), 0);
    chk("a.midrst.high_width", 64'(hw_a), 0);
    chk("a.midrst.tick_count", 64'(tc_a), 0);
    chk("a.midrst.stalled", 64'(st_a), 0);
    drive(0, 1'b1, 1);
    drive(0, 1'b0, 2);
    run(0, 2, 2, 3);
    chk("a.midrst.period_after", 64'(per_a), 4);

    // Narrow counters: tick_count wrap, then saturating period / high width
    run(1, 2, 2, 17);
    chk("b.wrap.tick_count", 64'(tc_b), 1);
    run(1, 18, 2, 3);
    drive(1, 1'b0, 3);
    chk("b.sat.period", 64'(per_b), 15);
    chk("b.sat.high_width", 64'(hw_b), 15);
    chk("b.sat.tick_count", 64'(tc_b), 4);
    chk("b.sat.stalled", 64'(st_b), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
